// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU function codes, widths and slot state type
package alu_pkg;

    localparam int WIDTH = 32;
    localparam int FW    = 4;
    localparam int SW    = 5;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter with registered preference pointer
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] elig,
    output logic [1:0] grant
);

    logic rr_ptr;

    // Grants are suppressed while reset is held so no request is accepted.
    always_comb begin
        grant = 2'b00;
        if (!rst) begin
            if (elig == 2'b11) begin
                grant = rr_ptr ? 2'b10 : 2'b01;
            end else begin
                grant = elig;
            end
        end
    end

    // The port just served loses preference, whether or not it was contended.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= 1'b0;
        end else if (grant[0]) begin
            rr_ptr <= 1'b1;
        end else if (grant[1]) begin
            rr_ptr <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one alu32 between two requesters with one-entry response slots
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = alu_pkg::WIDTH,
    parameter int FW    = alu_pkg::FW,
    parameter int SW    = alu_pkg::SW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [FW-1:0]    req0_f,
    input  logic [SW-1:0]    req0_shamt,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_y,
    output logic             rsp0_zero,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [FW-1:0]    req1_f,
    input  logic [SW-1:0]    req1_shamt,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_y,
    output logic             rsp1_zero,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [FW-1:0]    alu_f,
    output logic [SW-1:0]    alu_shamt,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             alu_zero
);

    logic [1:0]       req_valid;
    logic [1:0]       rsp_ready;
    logic [1:0]       elig;
    logic [1:0]       grant;
    slot_state_t      state [2];
    logic [WIDTH-1:0] slot_y [2];
    logic             slot_z [2];

    assign req_valid = {req1_valid, req0_valid};
    assign rsp_ready = {rsp1_ready, rsp0_ready};

    // A full slot can still accept when it is being drained this same cycle.
    always_comb begin
        elig = 2'b00;
        for (int n = 0; n < 2; n++) begin
            elig[n] = req_valid[n] && ((state[n] == SLOT_EMPTY) || rsp_ready[n]);
        end
    end

    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .elig  (elig),
        .grant (grant)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    always_comb begin
        alu_a     = '0;
        alu_b     = '0;
        alu_f     = '0;
        alu_shamt = '0;
        if (grant[0]) begin
            alu_a     = req0_a;
            alu_b     = req0_b;
            alu_f     = req0_f;
            alu_shamt = req0_shamt;
        end else if (grant[1]) begin
            alu_a     = req1_a;
            alu_b     = req1_b;
            alu_f     = req1_f;
            alu_shamt = req1_shamt;
        end
    end

    // Fill takes priority over pop so a same-cycle pop+fill stays full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < 2; n++) begin
                state[n]  <= SLOT_EMPTY;
                slot_y[n] <= '0;
                slot_z[n] <= 1'b0;
            end
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (grant[n]) begin
                    state[n]  <= SLOT_FULL;
                    slot_y[n] <= alu_y;
                    slot_z[n] <= alu_zero;
                end else if ((state[n] == SLOT_FULL) && rsp_ready[n]) begin
                    state[n] <= SLOT_EMPTY;
                end
            end
        end
    end

    assign rsp0_valid = (state[0] == SLOT_FULL);
    assign rsp1_valid = (state[1] == SLOT_FULL);
    assign rsp0_y     = slot_y[0];
    assign rsp1_y     = slot_y[1];
    assign rsp0_zero  = slot_z[0];
    assign rsp1_zero  = slot_z[1];

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter with a stand-in alu32
module tb_alu_arbiter;
    import alu_pkg::*;

    logic        clk;
    logic        rst;
    logic        req_valid [2];
    logic [31:0] req_a [2];
    logic [31:0] req_b [2];
    logic [3:0]  req_f [2];
    logic [4:0]  req_shamt [2];
    logic        rsp_ready [2];

    logic        req0_ready, req1_ready;
    logic        rsp0_valid, rsp1_valid;
    logic [31:0] rsp0_y, rsp1_y;
    logic        rsp0_zero, rsp1_zero;
    logic [31:0] alu_a, alu_b, alu_y;
    logic [3:0]  alu_f;
    logic [4:0]  alu_shamt;
    logic        alu_zero;

    int errors = 0;
    int checks = 0;

    alu_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req_valid[0]),
        .req0_ready (req0_ready),
        .req0_a     (req_a[0]),
        .req0_b     (req_b[0]),
        .req0_f     (req_f[0]),
        .req0_shamt (req_shamt[0]),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp_ready[0]),
        .rsp0_y     (rsp0_y),
        .rsp0_zero  (rsp0_zero),
        .req1_valid (req_valid[1]),
        .req1_ready (req1_ready),
        .req1_a     (req_a[1]),
        .req1_b     (req_b[1]),
        .req1_f     (req_f[1]),
        .req1_shamt (req_shamt[1]),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp_ready[1]),
        .rsp1_y     (rsp1_y),
        .rsp1_zero  (rsp1_zero),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_f      (alu_f),
        .alu_shamt  (alu_shamt),
        .alu_y      (alu_y),
        .alu_zero   (alu_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] f, input logic [4:0] sh);
        case (f)
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_SLT: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return a << sh;
        endcase
    endfunction

    // Stand-in for the shared alu32 instance.
    always_comb begin
        alu_y    = alu_ref(alu_a, alu_b, alu_f, alu_shamt);
        alu_zero = (alu_y == 32'd0);
    end

    // Reference model: what each response slot holds and who is preferred.
    bit          m_full [2];
    logic [31:0] m_y [2];
    bit          m_z [2];
    int          m_pref;
    int          m_grant;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int n = 0; n < 2; n++) begin
            m_full[n] = 0;
            m_y[n]    = 32'd0;
            m_z[n]    = 0;
        end
        m_pref = 0;
    endtask

    task automatic model_check();
        bit e0, e1;
        e0 = req_valid[0] && (!m_full[0] || rsp_ready[0]);
        e1 = req_valid[1] && (!m_full[1] || rsp_ready[1]);
        if (e0 && e1)  m_grant = m_pref;
        else if (e0)   m_grant = 0;
        else if (e1)   m_grant = 1;
        else           m_grant = -1;
        chk("req0_ready", {31'd0, req0_ready}, {31'd0, m_grant == 0});
        chk("req1_ready", {31'd0, req1_ready}, {31'd0, m_grant == 1});
        chk("alu_a", alu_a, (m_grant >= 0) ? req_a[m_grant] : 32'd0);
        chk("alu_b", alu_b, (m_grant >= 0) ? req_b[m_grant] : 32'd0);
        chk("alu_f", {28'd0, alu_f}, (m_grant >= 0) ? {28'd0, req_f[m_grant]} : 32'd0);
        chk("alu_shamt", {27'd0, alu_shamt}, (m_grant >= 0) ? {27'd0, req_shamt[m_grant]} : 32'd0);
        chk("rsp0_valid", {31'd0, rsp0_valid}, {31'd0, m_full[0]});
        chk("rsp1_valid", {31'd0, rsp1_valid}, {31'd0, m_full[1]});
        if (m_full[0]) begin
            chk("rsp0_y", rsp0_y, m_y[0]);
            chk("rsp0_zero", {31'd0, rsp0_zero}, {31'd0, m_z[0]});
        end
        if (m_full[1]) begin
            chk("rsp1_y", rsp1_y, m_y[1]);
            chk("rsp1_zero", {31'd0, rsp1_zero}, {31'd0, m_z[1]});
        end
    endtask

    task automatic model_update();
        logic [31:0] r;
        for (int n = 0; n < 2; n++) begin
            if (m_full[n] && rsp_ready[n]) m_full[n] = 0;
        end
        if (m_grant >= 0) begin
            r = alu_ref(req_a[m_grant], req_b[m_grant], req_f[m_grant], req_shamt[m_grant]);
            m_full[m_grant] = 1;
            m_y[m_grant]    = r;
            m_z[m_grant]    = (r == 32'd0);
            m_pref          = 1 - m_grant;
        end
    endtask

    // Called just after a rising edge with inputs already driven.
    task automatic step();
        @(negedge clk);
        model_check();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic set_req(input int n, input logic v, input logic [31:0] a,
                           input logic [31:0] b, input logic [3:0] f);
        req_valid[n] = v;
        req_a[n]     = a;
        req_b[n]     = b;
        req_f[n]     = f;
        req_shamt[n] = 5'd0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    typedef struct {
        logic        v0;
        logic [31:0] a0, b0;
        logic [3:0]  f0;
        logic        v1;
        logic [31:0] a1, b1;
        logic [3:0]  f1;
        logic        r0, r1;
        logic        e_rdy0, e_rdy1;
        logic        e_rv0;
        logic [31:0] e_y0;
        logic        e_z0;
        logic        e_rv1;
        logic [31:0] e_y1;
        logic        e_z1;
    } vec_t;

    vec_t vecs [14];

    logic [3:0] fcodes [6];

    initial begin
        vecs[0]  = '{1'b1, 32'hFFFFFFFF, 32'd4, ALU_ADD, 1'b0, 32'd0, 32'd0, ALU_AND, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0,  1'b0, 1'b0, 32'd0, 1'b0};
        vecs[1]  = '{1'b1, 32'd7, 32'd7, ALU_SUB, 1'b1, 32'd1, 32'd2, ALU_OR,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'd3,  1'b0, 1'b0, 32'd0, 1'b0};
        vecs[2]  = '{1'b1, 32'd7, 32'd7, ALU_SUB, 1'b1, 32'd1, 32'd2, ALU_OR,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0,  1'b0, 1'b1, 32'd3, 1'b0};
        vecs[3]  = '{1'b1, 32'd7, 32'd7, ALU_SUB, 1'b1, 32'd1, 32'd2, ALU_OR,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'd0,  1'b1, 1'b0, 32'd0, 1'b0};
        vecs[4]  = '{1'b1, 32'd7, 32'd7, ALU_SUB, 1'b1, 32'd1, 32'd2, ALU_OR,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0,  1'b0, 1'b1, 32'd3, 1'b0};
        vecs[5]  = '{1'b1, 32'd4, 32'd6, ALU_ADD, 1'b1, 32'd1, 32'd2, ALU_OR,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'd0,  1'b1, 1'b0, 32'd0, 1'b0};
        vecs[6]  = '{1'b1, 32'd4, 32'd6, ALU_ADD, 1'b1, 32'd1, 32'd2, ALU_OR,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0,  1'b0, 1'b1, 32'd3, 1'b0};
        vecs[7]  = '{1'b1, 32'd2, 32'd3, ALU_SLT, 1'b1, 32'd1, 32'd2, ALU_OR,  1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'd10, 1'b0, 1'b1, 32'd3, 1'b0};
        vecs[8]  = '{1'b0, 32'd2, 32'd3, ALU_SLT, 1'b1, 32'd1, 32'd2, ALU_OR,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd1,  1'b0, 1'b1, 32'd3, 1'b0};
        vecs[9]  = '{1'b0, 32'd0, 32'd0, ALU_AND, 1'b0, 32'd0, 32'd0, ALU_AND, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd1,  1'b0, 1'b1, 32'd3, 1'b0};
        vecs[10] = '{1'b1, 32'd1, 32'd1, ALU_AND, 1'b1, 32'd8, 32'd1, ALU_AND, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'd1,  1'b0, 1'b1, 32'd3, 1'b0};
        vecs[11] = '{1'b0, 32'd0, 32'd0, ALU_AND, 1'b0, 32'd0, 32'd0, ALU_AND, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'd1,  1'b0, 1'b1, 32'd0, 1'b1};
        vecs[12] = '{1'b0, 32'd0, 32'd0, ALU_AND, 1'b0, 32'd0, 32'd0, ALU_AND, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0,  1'b0, 1'b0, 32'd0, 1'b0};
        vecs[13] = '{1'b1, 32'd7, 32'd7, ALU_SUB, 1'b1, 32'd1, 32'd2, ALU_OR,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0,  1'b0, 1'b0, 32'd0, 1'b0};

        fcodes[0] = ALU_AND;
        fcodes[1] = ALU_OR;
        fcodes[2] = ALU_ADD;
        fcodes[3] = ALU_SUB;
        fcodes[4] = ALU_SLT;
        fcodes[5] = 4'b1000;

        for (int n = 0; n < 2; n++) begin
            set_req(n, 1'b0, 32'd0, 32'd0, ALU_AND);
            rsp_ready[n] = 1'b0;
        end
        rst = 1'b0;
        #2;

        // Reset arriving while a result is waiting in slot 0.
        do_reset();
        chk("reset_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
        chk("reset_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
        set_req(0, 1'b1, 32'd5, 32'd3, ALU_ADD);
        step();
        #3;
        chk("pre_reset_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
        chk("pre_reset_rsp0_y", rsp0_y, 32'd8);
        rst = 1'b1;
        #1;
        chk("async_reset_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
        chk("async_reset_rsp0_y", rsp0_y, 32'd0);
        chk("reset_req0_ready", {31'd0, req0_ready}, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        set_req(1, 1'b1, 32'd1, 32'd2, ALU_OR);
        rsp_ready[0] = 1'b1;
        rsp_ready[1] = 1'b1;
        #3;
        chk("post_reset_pref_req0", {31'd0, req0_ready}, 32'd1);
        chk("post_reset_pref_req1", {31'd0, req1_ready}, 32'd0);
        step();

        // Directed table: single op, contention, backpressure, pop+fill, idle.
        set_req(0, 1'b0, 32'd0, 32'd0, ALU_AND);
        set_req(1, 1'b0, 32'd0, 32'd0, ALU_AND);
        rsp_ready[0] = 1'b0;
        rsp_ready[1] = 1'b0;
        do_reset();
        for (int i = 0; i < 14; i++) begin
            set_req(0, vecs[i].v0, vecs[i].a0, vecs[i].b0, vecs[i].f0);
            set_req(1, vecs[i].v1, vecs[i].a1, vecs[i].b1, vecs[i].f1);
            rsp_ready[0] = vecs[i].r0;
            rsp_ready[1] = vecs[i].r1;
            #3;
            chk($sformatf("vec%0d_req0_ready", i), {31'd0, req0_ready}, {31'd0, vecs[i].e_rdy0});
            chk($sformatf("vec%0d_req1_ready", i), {31'd0, req1_ready}, {31'd0, vecs[i].e_rdy1});
            chk($sformatf("vec%0d_rsp0_valid", i), {31'd0, rsp0_valid}, {31'd0, vecs[i].e_rv0});
            chk($sformatf("vec%0d_rsp1_valid", i), {31'd0, rsp1_valid}, {31'd0, vecs[i].e_rv1});
            if (vecs[i].e_rv0) begin
                chk($sformatf("vec%0d_rsp0_y", i), rsp0_y, vecs[i].e_y0);
                chk($sformatf("vec%0d_rsp0_zero", i), {31'd0, rsp0_zero}, {31'd0, vecs[i].e_z0});
            end
            if (vecs[i].e_rv1) begin
                chk($sformatf("vec%0d_rsp1_y", i), rsp1_y, vecs[i].e_y1);
                chk($sformatf("vec%0d_rsp1_zero", i), {31'd0, rsp1_zero}, {31'd0, vecs[i].e_z1});
            end
            step();
        end

        // Randomised traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            for (int n = 0; n < 2; n++) begin
                req_valid[n] = ($urandom_range(0, 3) != 0);
                rsp_ready[n] = ($urandom_range(0, 2) != 0);
                req_a[n]     = ($urandom_range(0, 1) != 0) ? $urandom : $urandom_range(0, 15);
                req_b[n]     = ($urandom_range(0, 3) == 0) ? req_a[n] : $urandom;
                req_f[n]     = fcodes[$urandom_range(0, 5)];
                req_shamt[n] = 5'($urandom_range(0, 31));
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one alu32 instance between two requesters, e.g. the main EX stage and an auxiliary address/branch-compare unit.
- Each requester issues an operation with a valid/ready handshake. Round-robin arbitration picks one per cycle and drives the shared ALU combinationally.
- The ALU result is captured into that requester's one-entry response slot, returned with a valid/ready handshake one cycle later.

Parameters:
- WIDTH, 32, operand/result width; must match alu32.
- FW, 4, ALU function code width.
- SW, 5, shift amount width.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_a / req0_b  in  WIDTH  requester 0 operands (signed)
- req0_f  in  FW  requester 0 function code
- req0_shamt  in  SW  requester 0 shift amount
- rsp0_valid  out  1  requester 0 result available
- rsp0_ready  in  1  requester 0 consumes result
- rsp0_y  out  WIDTH  requester 0 result
- rsp0_zero  out  1  requester 0 zero flag
- req1_* / rsp1_*: identical set for requester 1
- alu_a / alu_b  out  WIDTH  to alu32 a/b
- alu_f  out  FW  to alu32 f
- alu_shamt  out  SW  to alu32 shamt
- alu_y  in  WIDTH  from alu32 y
- alu_zero  in  1  from alu32 zero

Behaviour:
- Slot state per port: EMPTY/FULL, visible as rspN_valid.
  - Pop when FULL and rspN_ready.
  - Fill on grant to port N.
  - Pop and fill in the same cycle leaves the slot FULL with the new data.
- Eligibility: port N is eligible when reqN_valid && (slot EMPTY || (slot FULL && rspN_ready)).
- Arbitration (combinational):
  - rr_ptr names the preferred port.
  - Only one eligible → grant it.
  - Both eligible → grant rr_ptr.
  - None eligible → no grant.
- reqN_ready = grant to N. It may depend combinationally on reqN_valid, so requesters must not make valid depend on ready.
- ALU mux:
  - On grant, alu_a/b/f/shamt carry the granted port's fields that same cycle.
  - With no grant, all ALU outputs are driven 0.
- Capture: at the rising edge with a grant, slot N <= {alu_y, alu_zero} and slot becomes FULL.
- Latency: request accepted in cycle T → rspN_valid high in T+1. Throughput is one op per cycle total.
- Hold: slot data and rspN_valid stay stable while rspN_ready is low; no overwrite.
- rr_ptr update:
  - After a grant when both ports were eligible, rr_ptr <= other port.
  - After a single-eligible grant, rr_ptr <= port not granted.
  - Otherwise unchanged.
- Reset (async, immediate): rsp0_valid = rsp1_valid = 0, rsp*_y = 0, rsp*_zero = 0, rr_ptr = 0 (port 0 preferred).
  - In-flight ops and held results are discarded.
  - reqN_ready is 0 while rst is high.
- Signedness: operands pass through unmodified; no width conversion inside the block.

Decomposition:
- Shared package alu_pkg holds:
  - ALU_AND=4'b0000, ALU_OR=4'b0001, ALU_ADD=4'b0010, ALU_SUB=4'b0110, ALU_SLT=4'b0111.
  - WIDTH/FW/SW defaults.
- One sub-module, rr_arb2: 2-way round-robin arbiter (elig[1:0] in, grant[1:0] out, rr_ptr register with async reset).
- Response slots and ALU mux are written inline.

Test Plan:
1. Reset mid-operation: req0 granted (a=5, b=3, ALU_ADD), assert rst before rsp0_ready → rsp0_valid=0 and rsp0_y=0 immediately; after release, rr_ptr prefers port 0.
2. Single requester: req0 a=32'hFFFFFFFF, b=4, ALU_ADD, rsp0_ready=1 → req0_ready=1 same cycle; next cycle rsp0_valid=1, rsp0_y=32'h00000003, rsp0_zero=0.
3. Contention: both valid every cycle with rsp ready; req0 = (7, 7, ALU_SUB), req1 = (1, 2, ALU_OR) → grants alternate 0, 1, 0, 1; rsp0_y=0 with rsp0_zero=1; rsp1_y=3 with rsp1_zero=0.
4. Backpressure: rsp1_ready=0 with rsp1 FULL, req1 valid → req1_ready=0, rsp1_y held stable for 5 cycles; req0 granted every cycle meanwhile.
5. Pop and fill same cycle: rsp0 FULL (y=10), rsp0_ready=1, req0 valid (2, 3, ALU_SLT) → req0_ready=1; next cycle rsp0_valid=1, rsp0_y=1.
6. Idle: no requests → alu_a/b/f/shamt all 0, no rspN_valid change, rr_ptr unchanged.
